core_msg_rx: RTL and testbench
==============================

Name: core_msg_rx

Overview:
- Per-core receiver for the scheduler broadcast bus; one instance per core, selected by its CORE_ID.
- Decodes the per-frame word stream: core mask, r0 mask, r0 data, instruction words.
- Captures its own r0 value and instruction stream into a local instruction buffer, then hands the task to the core datapath.
- Returns core_reading and core_ready bits to the scheduler.

Parameters:
- CORE_ID, 0, index of this core within the 16-bit masks.
- INSTR_SIZE, 16, width of the bus word and of each instruction.
- IMEM_DEPTH, 64, local instruction buffer depth in words.
- IMEM_AW, 6, instruction buffer address width (log2 IMEM_DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- mess_to_core  in  16  broadcast word from the scheduler.
- core_mask_loading  in  1  mess_to_core holds the task core mask this cycle.
- r0_mask_loading  in  1  mess_to_core holds the r0-init mask this cycle.
- r0_loading  in  1  mess_to_core holds one r0 data word this cycle.
- instr_loading  in  1  mess_to_core holds one instruction word this cycle.
- exec_done  in  1  one-cycle pulse from the core: task finished.
- imem_rd_addr  in  IMEM_AW  core fetch address.
- imem_rd_data  out  INSTR_SIZE  instruction at imem_rd_addr, combinational read.
- r0_value  out  16  captured r0 init value.
- r0_valid  out  1  r0_value was written for the current task.
- instr_count  out  IMEM_AW+1  number of instructions stored for the current task.
- start  out  1  one-cycle pulse: the task is loaded and the core may execute.
- core_reading  out  1  to scheduler: this core accepts bus words.
- core_ready  out  1  to scheduler: this core is idle (not executing).

Behaviour:
- Reset values: all outputs 0, except core_reading=1 and core_ready=1. FSM=IDLE, pointers=0.
- Loading flags are mutually exclusive by protocol.
  - If more than one flag is high, priority is core_mask > r0_mask > r0 > instr.
  - Lower-priority flags in that cycle are ignored.
- States: IDLE, MASKED, LOAD, RUN.
- IDLE:
  - On core_mask_loading, when mess_to_core[CORE_ID]=1: go to MASKED. Clear r0_valid, instr_count, wr_ptr and r0_idx.
  - When mess_to_core[CORE_ID]=0: stay in IDLE. All other flags are ignored until the next core_mask_loading.
- MASKED:
  - On r0_mask_loading, latch sel_r0 = mess_to_core[CORE_ID].
  - On each r0_loading, r0_idx increments (4-bit, saturates at 15).
  - When r0_idx==CORE_ID and sel_r0=1, r0_value <= word and r0_valid <= 1.
  - On the first instr_loading, write the word to imem[0] and go to LOAD.
- LOAD:
  - Each instr_loading writes imem[wr_ptr]; wr_ptr and instr_count increment.
  - When instr_count==IMEM_DEPTH, further words are dropped. No wrap; core_reading stays 1 so the scheduler never stalls.
  - The task ends on the first cycle with no flag high after at least one instruction word. That cycle: start=1, go to RUN.
  - core_mask_loading while in LOAD: end the current task (start=1, go to RUN). The new mask is ignored; the scheduler keeps it pending because core_reading drops.
- RUN:
  - core_ready=0 and core_reading=0. All bus flags are ignored.
  - exec_done: go to IDLE next cycle; core_ready=1 and core_reading=1 from that cycle on.
- A core_mask_loading in the same cycle as exec_done is not captured (core_reading was 0).
- Latencies:
  - The imem write is visible on imem_rd_data the cycle after the write.
  - start is high for exactly one cycle.
- Reset mid-task: returns to IDLE immediately. Buffer contents are undefined; instr_count=0.

Optional Feature:
- Macro: CORE_RX_ERR_EN.
- Defined: adds output port proto_err (1 bit), sticky until reset. Set on any of:
  - two or more loading flags high in the same cycle;
  - instr_loading or r0_loading while in MASKED before r0_mask_loading was seen... except that instr_loading in MASKED without a preceding r0_mask is allowed;
  - instruction overflow (word dropped at full buffer);
  - r0_loading while in LOAD.
- Undefined: no port, no logic; the behaviour above is otherwise unchanged.

Decomposition:
- Shared package (gpu_def): FSM state encodings RX_IDLE/RX_MASKED/RX_LOAD/RX_RUN, the bus word width, and the 16-bit core-mask width already used by the scheduler.
- One sub-module, core_imem: simple-dual-port IMEM_DEPTH x INSTR_SIZE buffer with synchronous write and combinational read.

Test Plan:
- CORE_ID=3, mask 0x0008, r0 mask 0x0008, 5 r0 words 0x10..0x14, 4 instr words A0..A3, idle cycle -> r0_value=0x13, r0_valid=1, instr_count=4, start pulse, core_ready=0, imem[0..3]=A0..A3.
- CORE_ID=3, mask 0x0004 plus a full stream -> stays IDLE, no start, core_reading=1 throughout.
- mask 0x0008, r0 mask 0x0000 -> r0_valid=0 at start.
- 70 instruction words -> instr_count=64, imem[63] = word 63, extra words dropped; proto_err=1 when CORE_RX_ERR_EN is defined.
- In RUN, pulse exec_done -> core_ready and core_reading both 1 on the next cycle; a following mask 0x0008 restarts loading with instr_count cleared.
- Assert reset in the middle of LOAD -> next cycle state IDLE, outputs at reset values, instr_count=0.

Source files
------------

// File: rtl/gpu_def.sv
// ---------------------------------------------------------------------------
// gpu_def
// Definitions shared by the scheduler and the per-core receivers:
//   - rx_state_e  : receiver FSM states (RX_IDLE, RX_MASKED, RX_LOAD, RX_RUN)
//   - BUS_W       : width of a scheduler broadcast word
//   - CORE_MASK_W : width of the core / r0 selection masks
//   - core_selected() : tests whether a core's bit is set in a mask word
// ---------------------------------------------------------------------------
package gpu_def;

    localparam int BUS_W       = 16;
    localparam int CORE_MASK_W = 16;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_MASKED = 2'd1,
        RX_LOAD   = 2'd2,
        RX_RUN    = 2'd3
    } rx_state_e;

    function automatic logic core_selected(input logic [CORE_MASK_W-1:0] mask,
                                           input int                     id);
        return mask[id];
    endfunction

endpackage

// File: rtl/core_imem.sv
// ---------------------------------------------------------------------------
// core_imem
// Simple dual-port instruction buffer: one synchronous write port, one
// combinational read port. A word written on a clock edge is visible on
// rd_data from the following cycle.
// Ports:
//   clk      in   clock, rising edge
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  word at rd_addr (combinational)
// The array has no reset; its contents are undefined until written.
// ---------------------------------------------------------------------------
module core_imem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/core_msg_rx.sv
// ---------------------------------------------------------------------------
// core_msg_rx
// Per-core receiver on the scheduler broadcast bus. Decodes the frame
// (core mask, r0 mask, r0 words, instruction words), keeps this core's r0
// value and instruction stream, pulses start when the task is loaded and
// reports core_reading / core_ready back to the scheduler.
// Ports:
//   clk, reset           clock (rising edge), synchronous active-high reset
//   mess_to_core         broadcast word
//   core_mask_loading    word is the task core mask
//   r0_mask_loading      word is the r0-init mask
//   r0_loading           word is one r0 data word (one per core, in order)
//   instr_loading        word is one instruction
//   exec_done            core finished its task (pulse)
//   imem_rd_addr/_data   core fetch port into the instruction buffer
//   r0_value, r0_valid   captured r0 and whether it was set for this task
//   instr_count          instructions stored for this task
//   start                one-cycle pulse: task loaded
//   core_reading         this core accepts bus words
//   core_ready           this core is not executing
//   proto_err            (only with CORE_RX_ERR_EN) sticky protocol error
// Optional feature macro: CORE_RX_ERR_EN
// ---------------------------------------------------------------------------
module core_msg_rx
    import gpu_def::*;
#(
    parameter int CORE_ID    = 0,
    parameter int INSTR_SIZE = 16,
    parameter int IMEM_DEPTH = 64,
    parameter int IMEM_AW    = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BUS_W-1:0]      mess_to_core,
    input  logic                  core_mask_loading,
    input  logic                  r0_mask_loading,
    input  logic                  r0_loading,
    input  logic                  instr_loading,
    input  logic                  exec_done,
    input  logic [IMEM_AW-1:0]    imem_rd_addr,
    output logic [INSTR_SIZE-1:0] imem_rd_data,
    output logic [BUS_W-1:0]      r0_value,
    output logic                  r0_valid,
    output logic [IMEM_AW:0]      instr_count,
    output logic                  start,
`ifdef CORE_RX_ERR_EN
    output logic                  proto_err,
`endif
    output logic                  core_reading,
    output logic                  core_ready
);

    localparam logic [IMEM_AW:0] FULL_COUNT = (IMEM_AW+1)'(IMEM_DEPTH);

    rx_state_e            state_q, state_d;
    logic                 sel_r0_q, sel_r0_d;
    logic [3:0]           r0_idx_q, r0_idx_d;
    logic [BUS_W-1:0]     r0_value_q, r0_value_d;
    logic                 r0_valid_q, r0_valid_d;
    logic [IMEM_AW:0]     instr_count_q, instr_count_d;

    logic                 imem_we;
    logic [IMEM_AW-1:0]   imem_wa;
    logic [IMEM_AW-1:0]   wr_ptr;
    logic                 buf_full;
    logic                 own_bit;
    logic                 any_flag;

    // Priority-resolved flags: core_mask > r0_mask > r0 > instr
    logic                 f_cm, f_rm, f_r0, f_il;

    assign f_cm     = core_mask_loading;
    assign f_rm     = r0_mask_loading & ~core_mask_loading;
    assign f_r0     = r0_loading & ~core_mask_loading & ~r0_mask_loading;
    assign f_il     = instr_loading & ~core_mask_loading & ~r0_mask_loading & ~r0_loading;
    assign any_flag = core_mask_loading | r0_mask_loading | r0_loading | instr_loading;
    assign own_bit  = core_selected(mess_to_core, CORE_ID);

    // The write pointer is the low bits of the count; the extra count bit
    // lets the count reach IMEM_DEPTH without wrapping.
    assign wr_ptr   = instr_count_q[IMEM_AW-1:0];
    assign buf_full = (instr_count_q == FULL_COUNT);

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        sel_r0_d      = sel_r0_q;
        r0_idx_d      = r0_idx_q;
        r0_value_d    = r0_value_q;
        r0_valid_d    = r0_valid_q;
        instr_count_d = instr_count_q;
        imem_we       = 1'b0;
        imem_wa       = wr_ptr;
        start         = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (f_cm && own_bit) begin
                    state_d       = RX_MASKED;
                    sel_r0_d      = 1'b0;
                    r0_idx_d      = '0;
                    r0_valid_d    = 1'b0;
                    instr_count_d = '0;
                end
            end
            RX_MASKED: begin
                if (f_rm) begin
                    sel_r0_d = own_bit;
                end else if (f_r0) begin
                    // r0 words arrive in core order; the index names the
                    // core the current word belongs to.
                    if (sel_r0_q && (r0_idx_q == 4'(CORE_ID))) begin
                        r0_value_d = mess_to_core;
                        r0_valid_d = 1'b1;
                    end
                    if (r0_idx_q != 4'hF) begin
                        r0_idx_d = r0_idx_q + 4'd1;
                    end
                end else if (f_il) begin
                    imem_we       = 1'b1;
                    imem_wa       = '0;
                    instr_count_d = (IMEM_AW+1)'(1);
                    state_d       = RX_LOAD;
                end
            end
            RX_LOAD: begin
                // A new core mask closes the task; core_reading drops so the
                // scheduler holds that mask until this core is idle again.
                if (f_cm || !any_flag) begin
                    start   = 1'b1;
                    state_d = RX_RUN;
                end else if (f_il && !buf_full) begin
                    imem_we       = 1'b1;
                    instr_count_d = instr_count_q + (IMEM_AW+1)'(1);
                end
            end
            RX_RUN: begin
                if (exec_done) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RX_IDLE;
            sel_r0_q      <= 1'b0;
            r0_idx_q      <= '0;
            r0_value_q    <= '0;
            r0_valid_q    <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            sel_r0_q      <= sel_r0_d;
            r0_idx_q      <= r0_idx_d;
            r0_value_q    <= r0_value_d;
            r0_valid_q    <= r0_valid_d;
            instr_count_q <= instr_count_d;
        end
    end

`ifdef CORE_RX_ERR_EN
    logic proto_err_q, proto_err_d;
    logic r0_mask_seen_q, r0_mask_seen_d;
    logic err_evt;

    // Protocol errors are only judged while this core listens to the bus;
    // during RUN the traffic belongs to other cores.
    always_comb begin
        r0_mask_seen_d = r0_mask_seen_q;
        err_evt        = 1'b0;
        if (state_q != RX_RUN && $countones({core_mask_loading, r0_mask_loading,
                                             r0_loading, instr_loading}) > 1) begin
            err_evt = 1'b1;
        end
        case (state_q)
            RX_IDLE: begin
                if (f_cm && own_bit) begin
                    r0_mask_seen_d = 1'b0;
                end
            end
            RX_MASKED: begin
                if (f_rm) begin
                    r0_mask_seen_d = 1'b1;
                end
                if (f_r0 && !r0_mask_seen_q) begin
                    err_evt = 1'b1;
                end
            end
            RX_LOAD: begin
                if (!f_cm && ((f_il && buf_full) || f_r0)) begin
                    err_evt = 1'b1;
                end
            end
            default: ;
        endcase
        proto_err_d = proto_err_q | err_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err_q    <= 1'b0;
            r0_mask_seen_q <= 1'b0;
        end else begin
            proto_err_q    <= proto_err_d;
            r0_mask_seen_q <= r0_mask_seen_d;
        end
    end

    assign proto_err = proto_err_q;
`endif

    core_imem #(
        .DEPTH (IMEM_DEPTH),
        .WIDTH (INSTR_SIZE),
        .AW    (IMEM_AW)
    ) u_imem (
        .clk     (clk),
        .wr_en   (imem_we),
        .wr_addr (imem_wa),
        .wr_data (INSTR_SIZE'(mess_to_core)),
        .rd_addr (imem_rd_addr),
        .rd_data (imem_rd_data)
    );

    assign r0_value     = r0_value_q;
    assign r0_valid     = r0_valid_q;
    assign instr_count  = instr_count_q;
    assign core_reading = (state_q != RX_RUN);
    assign core_ready   = (state_q != RX_RUN);

endmodule

// File: tb/tb_core_msg_rx.sv
// ---------------------------------------------------------------------------
// tb_core_msg_rx
// Directed bench for core_msg_rx with CORE_ID=3. A task-level reference
// model follows the frame rules and is compared on every falling edge;
// literal expectations at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_core_msg_rx;

    localparam int CID   = 3;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mess_to_core;
    logic        core_mask_loading;
    logic        r0_mask_loading;
    logic        r0_loading;
    logic        instr_loading;
    logic        exec_done;
    logic [5:0]  imem_rd_addr;
    logic [15:0] imem_rd_data;
    logic [15:0] r0_value;
    logic        r0_valid;
    logic [6:0]  instr_count;
    logic        start;
    logic        core_reading;
    logic        core_ready;
`ifdef CORE_RX_ERR_EN
    logic        proto_err;
`endif

    int compared   = 0;
    int mismatched = 0;

    core_msg_rx #(
        .CORE_ID    (CID),
        .INSTR_SIZE (16),
        .IMEM_DEPTH (DEPTH),
        .IMEM_AW    (6)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mess_to_core      (mess_to_core),
        .core_mask_loading (core_mask_loading),
        .r0_mask_loading   (r0_mask_loading),
        .r0_loading        (r0_loading),
        .instr_loading     (instr_loading),
        .exec_done         (exec_done),
        .imem_rd_addr      (imem_rd_addr),
        .imem_rd_data      (imem_rd_data),
        .r0_value          (r0_value),
        .r0_valid          (r0_valid),
        .instr_count       (instr_count),
        .start             (start),
`ifdef CORE_RX_ERR_EN
        .proto_err         (proto_err),
`endif
        .core_reading      (core_reading),
        .core_ready        (core_ready)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The task is tracked as: listening (not yet selected), selected for a
    // task but no instruction yet, collecting instructions, or executing.
    bit          mSelected;
    bit          mCollecting;
    bit          mExecuting;
    bit          mWantR0;
    int          mR0Seen;
    logic [15:0] mR0;
    bit          mR0Valid;
    int          mCount;
    logic [15:0] mMem [DEPTH];
    bit          mWritten [DEPTH];

    function automatic bit anyFlag();
        return core_mask_loading | r0_mask_loading | r0_loading | instr_loading;
    endfunction

    function automatic bit expStart();
        return mCollecting && (core_mask_loading || !anyFlag());
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mSelected = 0; mCollecting = 0; mExecuting = 0; mWantR0 = 0;
            mR0Seen = 0; mR0 = '0; mR0Valid = 0; mCount = 0;
            for (int i = 0; i < DEPTH; i++) mWritten[i] = 0;
        end else if (mExecuting) begin
            if (exec_done) mExecuting = 0;
        end else if (mCollecting) begin
            if (core_mask_loading || !anyFlag()) begin
                mCollecting = 0;
                mExecuting  = 1;
            end else if (!r0_mask_loading && !r0_loading && instr_loading && mCount < DEPTH) begin
                mMem[mCount] = mess_to_core;
                mWritten[mCount] = 1;
                mCount++;
            end
        end else if (mSelected) begin
            if (core_mask_loading) begin
                // ignored while waiting for the first instruction
            end else if (r0_mask_loading) begin
                mWantR0 = mess_to_core[CID];
            end else if (r0_loading) begin
                if (mWantR0 && mR0Seen == CID) begin
                    mR0 = mess_to_core;
                    mR0Valid = 1;
                end
                if (mR0Seen < 15) mR0Seen++;
            end else if (instr_loading) begin
                mMem[0] = mess_to_core;
                mWritten[0] = 1;
                mCount = 1;
                mSelected = 0;
                mCollecting = 1;
            end
        end else if (core_mask_loading && mess_to_core[CID]) begin
            mSelected = 1; mWantR0 = 0; mR0Seen = 0; mR0Valid = 0; mCount = 0;
        end
    end

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("core_ready",   32'(core_ready),   32'(!mExecuting));
            checkOutput("core_reading", 32'(core_reading), 32'(!mExecuting));
            checkOutput("start",        32'(start),        32'(expStart()));
            checkOutput("r0_valid",     32'(r0_valid),     32'(mR0Valid));
            checkOutput("r0_value",     32'(r0_value),     32'(mR0));
            checkOutput("instr_count",  32'(instr_count),  32'(mCount));
            if (mWritten[imem_rd_addr])
                checkOutput("imem_rd_data", 32'(imem_rd_data), 32'(mMem[imem_rd_addr]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input bit cm, input bit rm, input bit r0, input bit il,
                                 input bit done, input logic [15:0] word);
        core_mask_loading = cm;
        r0_mask_loading   = rm;
        r0_loading        = r0;
        instr_loading     = il;
        exec_done         = done;
        mess_to_core      = word;
        @(posedge clk);
        #1;
    endtask

    // Drives a quiet bus cycle and checks the start pulse within it.
    task automatic idleWithStart(input bit expected);
        core_mask_loading = 0; r0_mask_loading = 0; r0_loading = 0;
        instr_loading = 0; exec_done = 0; mess_to_core = '0;
        #1;
        checkOutput("start_lit", 32'(start), 32'(expected));
        @(posedge clk);
        #1;
    endtask

    task automatic readImem(input int addr, input logic [15:0] exp);
        imem_rd_addr = 6'(addr);
        #1;
        checkOutput("imem_lit", 32'(imem_rd_data), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1; mess_to_core = '0; core_mask_loading = 0; r0_mask_loading = 0;
        r0_loading = 0; instr_loading = 0; exec_done = 0; imem_rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready",   32'(core_ready),   32'd1);
        checkOutput("rst_reading", 32'(core_reading), 32'd1);
        checkOutput("rst_start",   32'(start),        32'd0);
        checkOutput("rst_count",   32'(instr_count),  32'd0);
        checkOutput("rst_r0v",     32'(r0_valid),     32'd0);
        checkOutput("rst_r0",      32'(r0_value),     32'd0);
        reset = 0;

        // Task 1: selected, r0 selected, 5 r0 words, 4 instructions
        applyStimulus(1, 0, 0, 0, 0, 16'h0008);
        applyStimulus(0, 1, 0, 0, 0, 16'h0008);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 0, 16'h0010 + 16'(i));
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 16'hA000 + 16'(i));
        idleWithStart(1);
        checkOutput("t1_r0",     32'(r0_value),     32'h13);
        checkOutput("t1_r0v",    32'(r0_valid),     32'd1);
        checkOutput("t1_count",  32'(instr_count),  32'd4);
        checkOutput("t1_ready",  32'(core_ready),   32'd0);
        checkOutput("t1_read",   32'(core_reading), 32'd0);
        for (int i = 0; i < 4; i++) readImem(i, 16'hA000 + 16'(i));
        applyStimulus(0, 0, 0, 0, 1, 16'h0000);
        checkOutput("t1_done_ready", 32'(core_ready),   32'd1);
        checkOutput("t1_done_read",  32'(core_reading), 32'd1);

        // Task 2: mask for another core; whole stream ignored
        applyStimulus(1, 0, 0, 0, 0, 16'h0004);
        applyStimulus(0, 1, 0, 0, 0, 16'h0008);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 16'h0020 + 16'(i));
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 16'hB000 + 16'(i));
        idleWithStart(0);
        checkOutput("t2_read",  32'(core_reading), 32'd1);
        checkOutput("t2_count", 32'(instr_count),  32'd4);

        // Task 3: no r0 selection; ended by a new core mask that also
        // carries an instruction flag (mask wins)
        applyStimulus(1, 0, 0, 0, 0, 16'h0008);
        applyStimulus(0, 1, 0, 0, 0, 16'h0000);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 16'h0030 + 16'(i));
        applyStimulus(0, 0, 0, 1, 0, 16'hC000);
        applyStimulus(0, 0, 0, 1, 0, 16'hC001);
        core_mask_loading = 1; instr_loading = 1; mess_to_core = 16'h0008;
        #1;
        checkOutput("t3_start_cm", 32'(start), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("t3_r0v",   32'(r0_valid),    32'd0);
        checkOutput("t3_count", 32'(instr_count), 32'd2);
        // exec_done together with a mask: mask not captured
        applyStimulus(1, 0, 0, 0, 1, 16'h0008);
        applyStimulus(0, 0, 0, 1, 0, 16'hD000);
        checkOutput("t3_idle_count", 32'(instr_count), 32'd2);
        checkOutput("t3_idle_ready", 32'(core_ready),  32'd1);

        // Task 4: overflow with 70 instructions
        applyStimulus(1, 0, 0, 0, 0, 16'h0008);
        for (int i = 0; i < 70; i++) applyStimulus(0, 0, 0, 1, 0, 16'h1000 + 16'(i));
        checkOutput("t4_count", 32'(instr_count), 32'd64);
        idleWithStart(1);
        readImem(63, 16'h103F);
        readImem(0,  16'h1000);
`ifdef CORE_RX_ERR_EN
        checkOutput("t4_proto_err", 32'(proto_err), 32'd1);
`endif
        applyStimulus(0, 0, 0, 0, 1, 16'h0000);
        checkOutput("t4_done_ready", 32'(core_ready), 32'd1);

        // Task 5: restart clears the count, then reset mid-load
        applyStimulus(1, 0, 0, 0, 0, 16'h0008);
        checkOutput("t5_cleared", 32'(instr_count), 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 16'h5555);
        applyStimulus(0, 0, 0, 1, 0, 16'h6666);
        checkOutput("t5_count", 32'(instr_count), 32'd2);
        reset = 1;
        applyStimulus(0, 0, 0, 0, 0, 16'h0000);
        checkOutput("t5_rst_count", 32'(instr_count),  32'd0);
        checkOutput("t5_rst_ready", 32'(core_ready),   32'd1);
        checkOutput("t5_rst_read",  32'(core_reading), 32'd1);
        checkOutput("t5_rst_start", 32'(start),        32'd0);
        checkOutput("t5_rst_r0v",   32'(r0_valid),     32'd0);
        reset = 0;
        applyStimulus(0, 0, 0, 1, 0, 16'h7777);
        checkOutput("t5_idle_after_rst", 32'(instr_count), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
